bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have port clk_sys_i, input, 1, system clock; all logic on its rising edge.
REQ-002 SHALL have port reset_ni, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have SPI ports: spi_addr_i in 17, spi_data_i in 8, spi_rw_ni in 1, spi_pending_i in 1, spi_done_o out 1, spi_data_o out 8.
REQ-004 SHALL have video ports: video_addr_i in 17, video_data_o out 8, video_valid_o out 1.
REQ-005 SHALL have CPU ports: cpu_addr_i in 17, cpu_data_i in 8, cpu_rw_ni in 1, cpu_ready_i in 1, cpu_en_o out 1, cpu_data_o out 8.
REQ-006 SHALL have RAM ports: ram_addr_o out 17, ram_data_i in 8, ram_data_o out 8, ram_data_oe_o out 1, ram_oe_no out 1, ram_we_no out 1.
REQ-007 SHALL have grant_o, out, 3, one-hot owner {cpu,video,spi}; 3'b000 = idle.

Function
REQ-008 SHALL keep a 4-bit frame counter cnt, +1 per clock, wrapping 15->0; slot = cnt[3:2], phase = cnt[1:0].
REQ-009 SHALL map slots: 0 = SPI, 1 = video A, 2 = video B, 3 = CPU; one frame = 16 clocks = one CPU cycle.
REQ-010 SHALL load a slot-owner register on the edge entering phase 0, holding it for all 4 phases of that slot.
REQ-011 SHALL make SPI owner of slot 0 only if spi_pending_i=1 and served=0, both sampled at the edge cnt 15->0; otherwise slot 0 idle.
REQ-012 SHALL set served=1 when an SPI slot is granted and clear it on any clock with spi_pending_i=0; no request served twice.
REQ-013 SHALL make video owner of slots 1 and 2 unconditionally.
REQ-014 SHALL make CPU owner of slot 3 only if cpu_ready_i=1 at the edge cnt 11->12; otherwise slot 3 idle, cpu_en_o stays 0.
REQ-015 SHALL drive ram_addr_o from the owner's address for the whole owned slot; value is don't-care when idle.
REQ-016 SHALL assert ram_oe_no=0 in phases 1-2 of an owned read slot; otherwise 1.
REQ-017 SHALL assert ram_we_no=0 in phases 1-2 of an owned write slot (owner rw_n=0); otherwise 1.
REQ-018 SHALL, on owned write slots, drive ram_data_o from owner data with ram_data_oe_o=1 in phases 1-3; else ram_data_oe_o=0.
REQ-019 SHALL never assert ram_oe_no=0 and ram_we_no=0 in the same clock.
REQ-020 SHALL latch ram_data_i into the owner's data output on the edge leaving phase 2 of a read slot; output holds otherwise.
REQ-021 SHALL pulse spi_done_o=1 for exactly the phase-3 clock of an owned SPI slot (read or write).
REQ-022 SHALL pulse video_valid_o=1 in phase 3 of slots 1 and 2 (cnt=7, cnt=11), video_data_o valid that clock.
REQ-023 SHALL pulse cpu_en_o=1 in phase 3 of an owned CPU slot (cnt=15).
REQ-024 SHALL reflect the current slot owner on grant_o; 000 in idle slots.
REQ-025 SHALL give an SPI request asserted at cnt=k a worst-case latency of 20 clocks to spi_done_o.

Reset
REQ-026 SHALL, while reset_ni=0 at an edge, set cnt=0, owner=idle, served=0, grant_o=000, ram_oe_no=1, ram_we_no=1, ram_data_oe_o=0, spi_done_o=0, video_valid_o=0, cpu_en_o=0, data outputs 8'h00.
REQ-027 SHALL abort any in-flight slot on reset mid-slot: strobes deassert next edge, no done/valid/en pulse for that slot.
REQ-028 SHALL leave the first slot 0 after reset release idle (owner not yet loaded); first frame resumes at cnt=1 on the first released edge.

Verification
REQ-029 Free-run, cpu_ready_i=1, no SPI -> video_valid_o at cnt 7,11, cpu_en_o at cnt 15, period 16, grant_o idle in slot 0.
REQ-030 SPI read addr 17'h08000, RAM model byte 8'hA5, pending raised cnt=5 -> grant_o=001 cnt 0-3 next frame, spi_data_o=8'hA5, spi_done_o one pulse at cnt=3, single access.
REQ-031 SPI write addr 17'h1FFFF data 8'h3C -> ram_we_no=0 exactly cnt 1-2, ram_data_oe_o=1 cnt 1-3, RAM model holds 8'h3C.
REQ-032 spi_pending_i held high 40 clocks after done -> no second grant; drop then re-raise -> new grant next slot 0.
REQ-033 cpu_ready_i=0 for 3 frames -> no cpu_en_o, ram strobes idle in slot 3, video unaffected.
REQ-034 reset_ni=0 at cnt=1 of granted SPI write -> ram_we_no=1 next edge, no spi_done_o, all REQ-026 values.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: fixed 16-clock TDM arbiter sharing one async SRAM between SPI, video and CPU.
// Frame = 4 slots of 4 phases; owner is chosen on the edge entering phase 0 and held for the slot.
module bus_arbiter (
   input  logic        clk_sys_i,
   input  logic        reset_ni,
   input  logic [16:0] spi_addr_i,
   input  logic [7:0]  spi_data_i,
   input  logic        spi_rw_ni,
   input  logic        spi_pending_i,
   output logic        spi_done_o,
   output logic [7:0]  spi_data_o,
   input  logic [16:0] video_addr_i,
   output logic [7:0]  video_data_o,
   output logic        video_valid_o,
   input  logic [16:0] cpu_addr_i,
   input  logic [7:0]  cpu_data_i,
   input  logic        cpu_rw_ni,
   input  logic        cpu_ready_i,
   output logic        cpu_en_o,
   output logic [7:0]  cpu_data_o,
   output logic [16:0] ram_addr_o,
   input  logic [7:0]  ram_data_i,
   output logic [7:0]  ram_data_o,
   output logic        ram_data_oe_o,
   output logic        ram_oe_no,
   output logic        ram_we_no,
   output logic [2:0]  grant_o
);
   // state     | meaning
   // OWN_IDLE  | slot unused, RAM strobes parked
   // OWN_SPI   | slot 0 granted to a fresh SPI request
   // OWN_VIDEO | slots 1 and 2, always video reads
   // OWN_CPU   | slot 3 granted because the CPU was ready
   localparam logic [1:0] OWN_IDLE  = 2'd0;
   localparam logic [1:0] OWN_SPI   = 2'd1;
   localparam logic [1:0] OWN_VIDEO = 2'd2;
   localparam logic [1:0] OWN_CPU   = 2'd3;

   logic [3:0] cnt_q, cnt_d;
   logic [1:0] owner_q, owner_d;
   logic       rw_n_q, rw_n_d;
   logic       served_q, served_d;
   logic       oe_n_q, oe_n_d, we_n_q, we_n_d, doe_q, doe_d;
   logic       spi_done_q, spi_done_d, video_valid_q, video_valid_d, cpu_en_q, cpu_en_d;
   logic [7:0] spi_rd_q, spi_rd_d, video_rd_q, video_rd_d, cpu_rd_q, cpu_rd_d;
   logic       owned_d, strobe_ph_d;

   always_comb begin
      cnt_d    = cnt_q + 4'd1;
      owner_d  = owner_q;
      rw_n_d   = rw_n_q;
      served_d = served_q & spi_pending_i;
      if (cnt_q[1:0] == 2'd3) begin
         case (cnt_q[3:2])
            2'd3: begin
               if (spi_pending_i && !served_q) begin
                  owner_d  = OWN_SPI;
                  rw_n_d   = spi_rw_ni;
                  served_d = 1'b1;
               end else begin
                  owner_d = OWN_IDLE;
                  rw_n_d  = 1'b1;
               end
            end
            2'd2: begin
               owner_d = cpu_ready_i ? OWN_CPU : OWN_IDLE;
               rw_n_d  = cpu_ready_i ? cpu_rw_ni : 1'b1;
            end
            default: begin
               owner_d = OWN_VIDEO;
               rw_n_d  = 1'b1;
            end
         endcase
      end

      // strobes and pulses are registered from next-state so the RAM pins are glitch-free
      owned_d       = (owner_d != OWN_IDLE);
      strobe_ph_d   = (cnt_d[1:0] == 2'd1) || (cnt_d[1:0] == 2'd2);
      oe_n_d        = !(owned_d && rw_n_d && strobe_ph_d);
      we_n_d        = !(owned_d && !rw_n_d && strobe_ph_d);
      doe_d         = owned_d && !rw_n_d && (cnt_d[1:0] != 2'd0);
      spi_done_d    = (owner_d == OWN_SPI) && (cnt_d[1:0] == 2'd3);
      video_valid_d = (owner_d == OWN_VIDEO) && (cnt_d[1:0] == 2'd3);
      cpu_en_d      = (owner_d == OWN_CPU) && (cnt_d[1:0] == 2'd3);

      spi_rd_d   = spi_rd_q;
      video_rd_d = video_rd_q;
      cpu_rd_d   = cpu_rd_q;
      if ((cnt_q[1:0] == 2'd2) && rw_n_q) begin
         case (owner_q)
            OWN_SPI:   spi_rd_d   = ram_data_i;
            OWN_VIDEO: video_rd_d = ram_data_i;
            OWN_CPU:   cpu_rd_d   = ram_data_i;
            default: ;
         endcase
      end
   end

   always_comb begin
      ram_addr_o = 17'd0;
      ram_data_o = 8'd0;
      grant_o    = 3'b000;
      case (owner_q)
         OWN_SPI: begin
            ram_addr_o = spi_addr_i;
            ram_data_o = spi_data_i;
            grant_o    = 3'b001;
         end
         OWN_VIDEO: begin
            ram_addr_o = video_addr_i;
            grant_o    = 3'b010;
         end
         OWN_CPU: begin
            ram_addr_o = cpu_addr_i;
            ram_data_o = cpu_data_i;
            grant_o    = 3'b100;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys_i) begin
      if (!reset_ni) begin
         cnt_q         <= 4'd0;
         owner_q       <= OWN_IDLE;
         rw_n_q        <= 1'b1;
         served_q      <= 1'b0;
         oe_n_q        <= 1'b1;
         we_n_q        <= 1'b1;
         doe_q         <= 1'b0;
         spi_done_q    <= 1'b0;
         video_valid_q <= 1'b0;
         cpu_en_q      <= 1'b0;
         spi_rd_q      <= 8'h00;
         video_rd_q    <= 8'h00;
         cpu_rd_q      <= 8'h00;
      end else begin
         cnt_q         <= cnt_d;
         owner_q       <= owner_d;
         rw_n_q        <= rw_n_d;
         served_q      <= served_d;
         oe_n_q        <= oe_n_d;
         we_n_q        <= we_n_d;
         doe_q         <= doe_d;
         spi_done_q    <= spi_done_d;
         video_valid_q <= video_valid_d;
         cpu_en_q      <= cpu_en_d;
         spi_rd_q      <= spi_rd_d;
         video_rd_q    <= video_rd_d;
         cpu_rd_q      <= cpu_rd_d;
      end
   end

   assign ram_oe_no     = oe_n_q;
   assign ram_we_no     = we_n_q;
   assign ram_data_oe_o = doe_q;
   assign spi_done_o    = spi_done_q;
   assign video_valid_o = video_valid_q;
   assign cpu_en_o      = cpu_en_q;
   assign spi_data_o    = spi_rd_q;
   assign video_data_o  = video_rd_q;
   assign cpu_data_o    = cpu_rd_q;

endmodule
